// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared operation encoding and request priority decode for the PC sequencer.
//   op_e      - the single operation executed in a cycle
//   decode_op - fixed priority ret > call > load > rel > inc, OP_NONE when idle
package pc_seq_pkg;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_INC,
        OP_REL,
        OP_LOAD,
        OP_CALL,
        OP_RET
    } op_e;

    function automatic op_e decode_op(
        input logic ret,
        input logic call,
        input logic load,
        input logic rel,
        input logic inc
    );
        return ret  ? OP_RET  :
               call ? OP_CALL :
               load ? OP_LOAD :
               rel  ? OP_REL  :
               inc  ? OP_INC  : OP_NONE;
    endfunction

endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: LIFO of return addresses for the PC sequencer.
//   clk, rst   - clock and asynchronous active-high reset (clears the pointer only)
//   push_i     - store data_i on top; ignored when full
//   pop_i      - discard the top entry; ignored when empty
//   data_i     - return address to push
//   data_o     - current top entry (valid only when not empty)
//   full_o     - pointer equals STACK_DEPTH
//   empty_o    - pointer equals zero
module pc_ret_stack #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] data_i,
    output logic [ADDR_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PW = $clog2(STACK_DEPTH);

    logic [ADDR_W-1:0] mem_q [STACK_DEPTH];
    logic [PW:0]       sp_q, sp_d;
    logic [PW-1:0]     top_idx;
    logic              do_push, do_pop;

    always_comb begin
        full_o  = sp_q == (PW+1)'(STACK_DEPTH);
        empty_o = sp_q == '0;
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        // The pointer names the next free slot, so the top lives one below it.
        top_idx = PW'(sp_q - 1'b1);
        data_o  = mem_q[top_idx];
        sp_d    = sp_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sp_q <= '0;
        else     sp_q <= sp_d;
    end

    // Entries at or above the pointer are never read, so the storage needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[sp_q[PW-1:0]] <= data_i;
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with increment, jump, relative branch, call/return stack and sticky stack errors.
//   clk, rst              - clock and asynchronous active-high reset
//   PC_en                 - global enable; 0 stalls everything except err_clr
//   PC_inc/load/rel       - increment, absolute jump to load_addr, branch by signed offset
//   PC_call/PC_ret        - push PC+1 and jump to load_addr / pop into PC
//   load_addr, offset     - jump/call target and two's-complement branch offset
//   err_clr               - clears stk_ovf/stk_unf unless a new error occurs the same cycle
//   PC                    - registered program counter
//   stk_full, stk_empty   - stack status
//   stk_ovf, stk_unf      - sticky call-on-full and return-on-empty flags
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_VEC   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PC_en,
    input  logic              PC_inc,
    input  logic              PC_load,
    input  logic              PC_rel,
    input  logic              PC_call,
    input  logic              PC_ret,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [ADDR_W-1:0] offset,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] PC,
    output logic              stk_full,
    output logic              stk_empty,
    output logic              stk_ovf,
    output logic              stk_unf
);

    op_e               op;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_next, top;
    logic              ovf_q, ovf_d, unf_q, unf_d;
    logic              push, pop, ovf_ev, unf_ev;

    pc_ret_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pc_next),
        .data_o  (top),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_comb begin
        op      = decode_op(PC_ret, PC_call, PC_load, PC_rel, PC_inc);
        pc_next = pc_q + ADDR_W'(1);
        push    = PC_en && op == OP_CALL && !stk_full;
        pop     = PC_en && op == OP_RET && !stk_empty;
        ovf_ev  = PC_en && op == OP_CALL && stk_full;
        unf_ev  = PC_en && op == OP_RET && stk_empty;
        // Same-width add wraps naturally; two's-complement offset makes rel a plain add.
        pc_d    = !PC_en         ? pc_q :
                  op == OP_RET   ? (stk_empty ? pc_q : top) :
                  op == OP_CALL  ? (stk_full ? pc_q : load_addr) :
                  op == OP_LOAD  ? load_addr :
                  op == OP_REL   ? pc_q + offset :
                  op == OP_INC   ? pc_next : pc_q;
        // A fresh error outranks a simultaneous clear.
        ovf_d   = ovf_ev || (ovf_q && !err_clr);
        unf_d   = unf_ev || (unf_q && !err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= ADDR_W'(RESET_VEC);
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign PC      = pc_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       PC_en = 1'b0, PC_inc = 1'b0, PC_load = 1'b0, PC_rel = 1'b0;
    logic       PC_call = 1'b0, PC_ret = 1'b0, err_clr = 1'b0;
    logic [7:0] load_addr = '0, offset = '0;
    logic [7:0] PC;
    logic       stk_full, stk_empty, stk_ovf, stk_unf;
    int         checks = 0;
    int         failures = 0;

    pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_VEC(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .PC_en     (PC_en),
        .PC_inc    (PC_inc),
        .PC_load   (PC_load),
        .PC_rel    (PC_rel),
        .PC_call   (PC_call),
        .PC_ret    (PC_ret),
        .load_addr (load_addr),
        .offset    (offset),
        .err_clr   (err_clr),
        .PC        (PC),
        .stk_full  (stk_full),
        .stk_empty (stk_empty),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One request vector for one rising edge; outputs are settled 1 time unit later.
    task automatic step(input logic en, input logic ret, input logic call, input logic ld,
                        input logic rel, input logic inc, input logic clr,
                        input logic [7:0] la, input logic [7:0] off);
        PC_en = en; PC_ret = ret; PC_call = call; PC_load = ld;
        PC_rel = rel; PC_inc = inc; err_clr = clr; load_addr = la; offset = off;
        @(posedge clk);
        #1;
        PC_en = 0; PC_ret = 0; PC_call = 0; PC_load = 0; PC_rel = 0; PC_inc = 0; err_clr = 0;
    endtask

    task automatic op_inc();                  step(1,0,0,0,0,1,0,8'h00,8'h00); endtask
    task automatic op_load(input logic [7:0] a); step(1,0,0,1,0,0,0,a,8'h00);   endtask
    task automatic op_call(input logic [7:0] a); step(1,0,1,0,0,0,0,a,8'h00);   endtask
    task automatic op_ret();                  step(1,1,0,0,0,0,0,8'h00,8'h00); endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_pc", PC, 8'h00);
        check("rst_empty", stk_empty, 1);
        check("rst_full", stk_full, 0);
        check("rst_ovf", stk_ovf, 0);
        check("rst_unf", stk_unf, 0);
        rst = 1'b0;

        op_inc(); check("inc1", PC, 8'h01);
        op_inc(); check("inc2", PC, 8'h02);
        op_inc(); check("inc3", PC, 8'h03);

        op_load(8'hFF); check("load_ff", PC, 8'hFF);
        op_inc();       check("inc_wrap", PC, 8'h00);

        op_load(8'h10);
        step(1,0,0,0,1,0,0,8'h00,8'hFE); check("rel_neg", PC, 8'h0E);

        op_load(8'h05);
        op_call(8'h40); check("call_pc", PC, 8'h40);
        check("call_nonempty", stk_empty, 0);
        op_ret();       check("ret_pc", PC, 8'h06);
        check("ret_empty", stk_empty, 1);

        op_call(8'h10);
        op_call(8'h20);
        op_call(8'h30);
        check("three_not_full", stk_full, 0);
        op_call(8'h40); check("four_full", stk_full, 1);
        check("four_pc", PC, 8'h40);
        op_call(8'h80); check("ovf_pc_hold", PC, 8'h40);
        check("ovf_set", stk_ovf, 1);
        step(1,0,0,0,0,0,1,8'h00,8'h00); check("ovf_clr", stk_ovf, 0);
        check("clr_pc_hold", PC, 8'h40);

        op_ret(); check("pop1", PC, 8'h31);
        check("pop1_not_full", stk_full, 0);
        op_ret(); check("pop2", PC, 8'h21);
        op_ret(); check("pop3", PC, 8'h11);
        op_ret(); check("pop4", PC, 8'h07);
        check("pop4_empty", stk_empty, 1);

        op_ret(); check("unf_pc_hold", PC, 8'h07);
        check("unf_set", stk_unf, 1);
        step(1,1,0,0,0,0,1,8'h00,8'h00); check("unf_beats_clr", stk_unf, 1);

        step(0,1,1,1,1,1,1,8'hAA,8'h55);
        check("stall_pc", PC, 8'h07);
        check("stall_clr_acts", stk_unf, 0);
        check("stall_empty", stk_empty, 1);
        check("stall_no_ovf", stk_ovf, 0);

        op_load(8'h21);
        op_call(8'h50); check("call_50", PC, 8'h50);
        step(1,1,1,1,0,1,0,8'h99,8'h00); check("prio_ret", PC, 8'h22);
        check("prio_ret_empty", stk_empty, 1);

        op_load(8'h30);
        step(1,0,0,0,1,1,0,8'h00,8'h05); check("prio_rel_over_inc", PC, 8'h35);
        step(1,0,0,1,1,0,0,8'h60,8'h05); check("prio_load_over_rel", PC, 8'h60);

        op_call(8'h70); check("call_70", PC, 8'h70);
        check("call_70_nonempty", stk_empty, 0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pc", PC, 8'h00);
        check("async_rst_empty", stk_empty, 1);
        #1 rst = 1'b0;
        op_ret(); check("post_rst_unf", stk_unf, 1);
        check("post_rst_pc", PC, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the program-counter and address width.
REQ-002 Parameter STACK_DEPTH, default 4, SHALL set the return-address stack depth (power of two, at least 2).
REQ-003 Parameter RESET_VEC, default 0, SHALL set the PC value loaded on reset.
REQ-004 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port PC_en, input, 1: the global enable; when 0, the block SHALL hold all state (stall).
REQ-007 Port PC_inc, input, 1: sequential increment request.
REQ-008 Port PC_load, input, 1: absolute jump request.
REQ-009 Port PC_rel, input, 1: relative branch request.
REQ-010 Port PC_call, input, 1: subroutine call request.
REQ-011 Port PC_ret, input, 1: subroutine return request.
REQ-012 Port load_addr, input, ADDR_W: the target for load and call.
REQ-013 Port offset, input, ADDR_W: the signed two's-complement branch offset.
REQ-014 Port err_clr, input, 1: clears the sticky error flags.
REQ-015 Port PC, output, ADDR_W: the registered program counter.
REQ-016 Port stk_full and stk_empty, outputs, 1 each: the stack status, combinational from the stack pointer.
REQ-017 Port stk_ovf and stk_unf, outputs, 1 each: sticky overflow and underflow error flags.

Function
REQ-018 With PC_en=1, exactly one operation SHALL execute per cycle, selected by the fixed priority ret > call > load > rel > inc; if no request is asserted, PC SHALL hold.
REQ-019 The inc operation SHALL set PC to PC+1 modulo 2^ADDR_W, so that all-ones wraps to 0.
REQ-020 The load operation SHALL set PC to load_addr.
REQ-021 The rel operation SHALL set PC to PC+offset modulo 2^ADDR_W, where offset is sign-interpreted.
REQ-022 When the stack is not full, call SHALL push PC+1 (wrapped) and set PC to load_addr in the same cycle.
REQ-023 When the stack is full, call SHALL neither push nor jump: PC holds and stk_ovf sets.
REQ-024 When the stack is not empty, ret SHALL pop the top entry into PC.
REQ-025 When the stack is empty, ret SHALL leave PC unchanged and set stk_unf.
REQ-026 Every operation SHALL have 1-cycle latency: the new PC is visible after the rising edge on which the request is sampled.
REQ-027 When PC_en=0, all requests SHALL be ignored, the error flags SHALL not be set, and err_clr SHALL still act.
REQ-028 If err_clr and a new error occur in the same cycle, the error SHALL win and the flag SHALL remain set.
REQ-029 The stack pointer SHALL count from 0 to STACK_DEPTH; stk_full SHALL be asserted at STACK_DEPTH and stk_empty at 0.

Reset
REQ-030 Reset SHALL asynchronously set PC=RESET_VEC, stack pointer=0, stk_ovf=0 and stk_unf=0.
REQ-031 Stack contents SHALL not require reset; only entries below the stack pointer are valid.
REQ-032 A reset asserted mid-sequence SHALL discard all pending calls, so the first later ret sets stk_unf.

Structure
REQ-033 Package pc_seq_pkg SHALL hold the operation-select enum (OP_NONE, OP_INC, OP_REL, OP_LOAD, OP_CALL, OP_RET) and the priority-decode function.
REQ-034 The return stack SHALL be the sub-module pc_ret_stack, with push/pop/data/full/empty ports and parameters ADDR_W and STACK_DEPTH.
REQ-035 The top level SHALL contain only the priority decode, the PC register, the adder muxing, and the error flags.

Verification
REQ-036 Reset, then PC_inc=1 for 3 cycles -> PC sequence 0x00, 0x01, 0x02, 0x03.
REQ-037 PC=0xFF, PC_inc=1 -> PC=0x00; PC=0x10, PC_rel=1, offset=0xFE -> PC=0x0E.
REQ-038 PC=0x05, PC_call=1, load_addr=0x40 -> PC=0x40 with stk_empty=0; then PC_ret=1 -> PC=0x06.
REQ-039 Four nested calls -> stk_full=1; a fifth call, load_addr=0x80 -> PC unchanged and stk_ovf=1; then err_clr=1 -> stk_ovf=0.
REQ-040 Empty stack, PC_ret=1 -> PC unchanged, stk_unf=1; all requests with PC_en=0 -> no state change.
REQ-041 PC_ret, PC_call, PC_load and PC_inc asserted together with one entry (0x22) on the stack -> PC=0x22; async rst mid-cycle -> PC=RESET_VEC immediately, stk_empty=1.
